// File: rtl/panda_pkg.sv
// Shared LSU types: controller state encoding and access-width encoding.
package panda_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        RESP1 = 3'd2,
        REQ2  = 3'd3,
        RESP2 = 3'd4
    } lsu_state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_width_e;

    // The reserved encoding 3 behaves exactly like a word access.
    function automatic lsu_width_e norm_width(input logic [1:0] w);
        return (w == 2'd3) ? WORD : lsu_width_e'(w);
    endfunction

endpackage

// File: rtl/panda_lsu_align.sv
// Byte-lane steering for the LSU: strobe mask, store rotation, load assembly and extension.
// Purely combinational, no state and no handshake.
module panda_lsu_align
    import panda_pkg::*;
(
    input  lsu_width_e  width_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] lo_word_i,
    input  logic [31:0] hi_word_i,
    output logic [7:0]  mask_o,
    output logic        split_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [3:0]  mask;
    logic [5:0]  sh_amt;
    logic [5:0]  sh_inv;
    logic [31:0] shifted;

    assign sh_amt = {1'b0, offset_i, 3'b000};
    assign sh_inv = 6'd32 - sh_amt;

    always_comb begin
        mask        = 4'b1111;
        load_data_o = '0;
        case (width_i)
            BYTE:    mask = 4'b0001;
            HALF:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        mask_o  = {4'b0000, mask} << offset_i;
        split_o = ((width_i == HALF) && (offset_i == 2'd3)) ||
                  ((width_i == WORD) && (offset_i != 2'd0));

        // A shift by 32 yields zero, so offset 0 degenerates cleanly to the unrotated word.
        wdata_o = (store_data_i << sh_amt) | (store_data_i >> sh_inv);
        shifted = (lo_word_i >> sh_amt) | (hi_word_i << sh_inv);

        case (width_i)
            BYTE:    load_data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            HALF:    load_data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/panda_lsu_split_ctrl.sv
// Load/store controller splitting misaligned accesses into two word-aligned bus transfers.
// done_o 3 cycles after acceptance (5 when split); bus outputs held until data_gnt_i, ready_o only in IDLE.
module panda_lsu_split_ctrl
    import panda_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        load_store_i,
    input  logic        load_unsigned_i,
    input  logic [1:0]  width_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_we_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    lsu_state_e  state_q, state_d;
    lsu_width_e  width_q, width_d;
    logic        ls_q, ls_d, uns_q, uns_d;
    logic        done_q, done_d, mis_q, mis_d;
    logic [31:0] addr_q, addr_d, sdata_q, sdata_d;
    logic [31:0] rdata1_q, rdata1_d, load_data_q, load_data_d;

    logic [7:0]  mask;
    logic        split;
    logic [31:0] wdata_rot, load_ext, lo_word, hi_word, base_addr;

    panda_lsu_align u_align (
        .width_i      (width_q),
        .offset_i     (addr_q[1:0]),
        .unsigned_i   (uns_q),
        .store_data_i (sdata_q),
        .lo_word_i    (lo_word),
        .hi_word_i    (hi_word),
        .mask_o       (mask),
        .split_o      (split),
        .wdata_o      (wdata_rot),
        .load_data_o  (load_ext)
    );

    // In RESP2 the first word was captured earlier; otherwise the live response is the low word.
    assign lo_word   = (state_q == RESP2) ? rdata1_q : data_rdata_i;
    assign hi_word   = (state_q == RESP2) ? data_rdata_i : 32'h0;
    assign base_addr = {addr_q[31:2], 2'b00};

    assign ready_o      = (state_q == IDLE);
    assign done_o       = done_q;
    assign misaligned_o = mis_q;
    assign load_data_o  = load_data_q;

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        ls_d         = ls_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        rdata1_d     = rdata1_q;
        done_d       = 1'b0;
        mis_d        = mis_q;
        load_data_d  = load_data_q;
        data_req_o   = 1'b0;
        data_addr_o  = 32'h0;
        data_we_o    = 4'b0000;
        data_wdata_o = 32'h0;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    ls_d    = load_store_i;
                    uns_d   = load_unsigned_i;
                    width_d = norm_width(width_i);
                    addr_d  = addr_i;
                    sdata_d = store_data_i;
                    state_d = REQ1;
                end
            end
            REQ1: begin
                data_req_o   = 1'b1;
                data_addr_o  = base_addr;
                data_we_o    = ls_q ? mask[3:0] : 4'b0000;
                data_wdata_o = wdata_rot;
                if (data_gnt_i) state_d = RESP1;
            end
            RESP1: begin
                if (data_rvalid_i) begin
                    if (split) begin
                        rdata1_d = data_rdata_i;
                        state_d  = REQ2;
                    end else begin
                        done_d      = 1'b1;
                        mis_d       = 1'b0;
                        load_data_d = ls_q ? 32'h0 : load_ext;
                        state_d     = IDLE;
                    end
                end
            end
            REQ2: begin
                data_req_o   = 1'b1;
                data_addr_o  = base_addr + 32'd4;
                data_we_o    = ls_q ? mask[7:4] : 4'b0000;
                data_wdata_o = wdata_rot;
                if (data_gnt_i) state_d = RESP2;
            end
            RESP2: begin
                if (data_rvalid_i) begin
                    done_d      = 1'b1;
                    mis_d       = 1'b1;
                    load_data_d = ls_q ? 32'h0 : load_ext;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            width_q     <= BYTE;
            ls_q        <= 1'b0;
            uns_q       <= 1'b0;
            addr_q      <= 32'h0;
            sdata_q     <= 32'h0;
            rdata1_q    <= 32'h0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            ls_q        <= ls_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            rdata1_q    <= rdata1_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            load_data_q <= load_data_d;
        end
    end

endmodule

// File: doc/panda_lsu_split_ctrl.md
PANDA_LSU_SPLIT_CTRL -- requirements
Module: panda_lsu_split_ctrl

Interface
REQ-001 SHALL have no parameters; data and address widths are fixed at 32 bits.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  1  core requests a load/store.
REQ-005 ready_o  output  1  controller can accept a request.
REQ-006 load_store_i  input  1  0 = load, 1 = store.
REQ-007 load_unsigned_i  input  1  zero-extend load result when 1.
REQ-008 width_i  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
REQ-009 addr_i  input  32  byte address.
REQ-010 store_data_i  input  32  store data, LSB-aligned.
REQ-011 done_o  output  1  one-cycle pulse; operation complete.
REQ-012 load_data_o  output  32  extended load result, valid while done_o is high.
REQ-013 misaligned_o  output  1  qualifies done_o; operation was split.
REQ-014 data_req_o  output  1  bus request.
REQ-015 data_gnt_i  input  1  bus grant.
REQ-016 data_rvalid_i  input  1  bus response; loads and stores.
REQ-017 data_addr_o  output  32  word-aligned bus address, bits [1:0] = 0.
REQ-018 data_we_o  output  4  byte write strobes; 0 for loads.
REQ-019 data_wdata_o  output  32  bus write data.
REQ-020 data_rdata_i  input  32  bus read data, valid with data_rvalid_i.

Function
REQ-021 SHALL implement FSM states IDLE, REQ1, RESP1, REQ2, RESP2.
REQ-022 ready_o SHALL be 1 only in IDLE; req_i && ready_o accepts and latches all request inputs; the next state is REQ1.
REQ-023 Split condition: half with addr[1:0] = 3, or word with addr[1:0] != 0; byte accesses are never split.
REQ-024 Byte mask: byte 4'b0001, half 4'b0011, word 4'b1111. The 8-bit shifted mask is mask << addr[1:0].
REQ-025 Access 1: data_addr_o = {addr[31:2], 2'b00}; strobes = shifted mask [3:0].
REQ-026 Access 2: data_addr_o = access-1 address + 4, wrapping modulo 2^32; strobes = shifted mask [7:4].
REQ-027 data_wdata_o SHALL be store data rotated left by 8*addr[1:0] for both accesses.
REQ-028 REQ1/REQ2: data_req_o = 1. Address, strobes and wdata are held stable until data_gnt_i.
REQ-029 On data_gnt_i, REQ1 goes to RESP1 and REQ2 goes to RESP2.
REQ-030 RESP1 on data_rvalid_i:
- split: capture data_rdata_i, go to REQ2;
- not split: complete, go to IDLE.
REQ-031 RESP2 on data_rvalid_i: complete, go to IDLE.
REQ-032 data_rvalid_i outside RESP1/RESP2 and data_gnt_i outside REQ1/REQ2 SHALL be ignored.
REQ-033 Completion: done_o pulses the cycle after the final rvalid, and load_data_o and misaligned_o are registered alongside it.
REQ-034 After completion, the next request SHALL be accepted in the same cycle as done_o.
REQ-035 Load assembly: 64-bit {second word, first word} shifted right by 8*addr[1:0], taking the low width bytes.
REQ-036 Load assembly: sign-extend from the top selected bit, or zero-extend when load_unsigned_i = 1.
REQ-037 For stores, load_data_o SHALL be 0.
REQ-038 Minimum latency with gnt and rvalid each in the first possible cycle:
- aligned: 3 cycles from acceptance to done_o;
- split: 5 cycles.

Reset
REQ-039 Asynchronous reset SHALL force IDLE from any state, including mid-split, and discard the latched request.
REQ-040 Reset values: ready_o 1; done_o, misaligned_o, data_req_o 0; data_we_o 0; load_data_o, data_addr_o, data_wdata_o 0.

Structure
REQ-041 The FSM state enum and width encodings (BYTE/HALF/WORD) SHALL live in shared package panda_pkg.
REQ-042 Mask/rotate and load-extension logic SHALL be one combinational sub-module, panda_lsu_align.
REQ-043 The controller SHALL be panda_lsu_split_ctrl, containing the FSM and registers.

Verification
REQ-044 Aligned word load, addr 0x100, rdata 0x89AB67EF -> one bus access; load_data_o 0x89AB67EF; misaligned_o 0.
REQ-045 Signed byte load, addr 0x103, rdata 0x89AB67EF -> bus addr 0x100, load_data_o 0xFFFFFF89; unsigned -> 0x00000089.
REQ-046 Word load, addr 0x102, rdata 0x89AB67EF then 0x12345678:
- bus addrs 0x100 then 0x104;
- load_data_o 0x567889AB; misaligned_o 1.
REQ-047 Half store, addr 0x103, data 0x12345678:
- access 1: addr 0x100, we 4'b1000, wdata 0x78123456;
- access 2: addr 0x104, we 4'b0001.
REQ-048 Gnt held low 3 cycles -> data_req_o, data_addr_o, data_we_o, data_wdata_o stable throughout; stray rvalid in IDLE is ignored.
REQ-049 rst_ni asserted in RESP1 of a split load -> immediate IDLE, data_req_o 0, no done_o; next request completes normally.
